capture_dma_writer: RTL and testbench

Avalon-MM burst-write initiator that drains 256-bit capture words into HPS SDRAM through the FPGA-to-SDRAM port. It sits between the capture FIFO (capture_clk_div8 domain output, already synchronised to `clk`) and the `f2h_sdram0_data` slave. It fills a software-defined ring buffer in SDRAM and reports its write pointer for the lightweight-bridge register file.

---
 rtl/la_pkg.sv | 16 +
 rtl/capture_dma_writer.sv | 145 ++++++++++++++
 tb/tb_capture_dma_writer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path: SDRAM port widths
// and the DMA writer state encoding.
package la_pkg;

  localparam int LA_SDRAM_ADDR_W = 27;
  localparam int LA_SDRAM_DATA_W = 256;
  localparam int LA_BURSTCOUNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ARM        = 2'd1,
    ST_BURST      = 2'd2,
    ST_FLUSH_WAIT = 2'd3
  } dma_state_t;

endpackage

// File: rtl/capture_dma_writer.sv
// Avalon-MM burst-write initiator filling an SDRAM ring buffer from the capture FIFO.
// Define CAPTURE_DMA_WRAP_EN to let the ring wrap; otherwise capture stops with status_full.
module capture_dma_writer
  import la_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int LEVEL_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ctrl_start,
  input  logic                       ctrl_stop,
  input  logic [LA_SDRAM_ADDR_W-1:0] ctrl_base,
  input  logic [LA_SDRAM_ADDR_W-1:0] ctrl_len,
  input  logic [LA_SDRAM_DATA_W-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LEVEL_W-1:0]         in_level,
  output logic [LA_SDRAM_ADDR_W-1:0] avm_address,
  output logic [LA_BURSTCOUNT_W-1:0] avm_burstcount,
  output logic                       avm_write,
  output logic [LA_SDRAM_DATA_W-1:0] avm_writedata,
  output logic [31:0]                avm_byteenable,
  output logic                       avm_read,
  input  logic                       avm_waitrequest,
  output logic                       status_busy,
  output logic [LA_SDRAM_ADDR_W-1:0] status_wptr,
  output logic                       status_wrapped,
  output logic                       status_full
);

  localparam logic [LEVEL_W-1:0]         BURST_LVL = LEVEL_W'(BURST_LEN);
  localparam logic [LA_BURSTCOUNT_W-1:0] BURST_BC  = LA_BURSTCOUNT_W'(BURST_LEN);

  dma_state_t state_q, state_d;

  logic [LA_SDRAM_ADDR_W-1:0] base_q, len_q, wptr_q, addr_q, wptr_next;
  logic [LA_BURSTCOUNT_W-1:0] bc_q, beat_q, arm_bc;
  logic wrapped_q, full_q, stop_pending_q;
  logic arm_full, arm_part, arm_done, beat_acc, last_beat, ring_end;

  // Handshake: a beat transfers on a cycle where avm_write is high and
  // avm_waitrequest is low; in_ready mirrors exactly that transfer, so the
  // upstream FIFO pops the same word the slave accepted.
  always_comb begin
    arm_full  = in_level >= BURST_LVL;
    arm_part  = stop_pending_q && (in_level != '0) && !arm_full;
    arm_done  = stop_pending_q && (in_level == '0);
    arm_bc    = arm_full ? BURST_BC : LA_BURSTCOUNT_W'(in_level);
    beat_acc  = (state_q == ST_BURST) && in_valid && !avm_waitrequest;
    last_beat = beat_acc && (beat_q == bc_q - 1'b1);
    wptr_next = wptr_q + LA_SDRAM_ADDR_W'(bc_q);
    ring_end  = (wptr_next == len_q);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ctrl_start) state_d = ST_ARM;
      ST_ARM: begin
        if (arm_full || arm_part) state_d = ST_BURST;
        else if (arm_done)        state_d = ST_IDLE;
      end
      ST_BURST: begin
        if (last_beat) begin
`ifdef CAPTURE_DMA_WRAP_EN
          state_d = ST_ARM;
`else
          state_d = ring_end ? ST_IDLE : ST_ARM;
`endif
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    avm_write   = (state_q == ST_BURST) && in_valid;
    in_ready    = beat_acc;
    status_busy = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q         <= '0;
      len_q          <= '0;
      wptr_q         <= '0;
      addr_q         <= '0;
      bc_q           <= '0;
      beat_q         <= '0;
      wrapped_q      <= 1'b0;
      full_q         <= 1'b0;
      stop_pending_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && ctrl_start) begin
        base_q         <= ctrl_base;
        len_q          <= ctrl_len;
        wptr_q         <= '0;
        wrapped_q      <= 1'b0;
        full_q         <= 1'b0;
        // A stop arriving with the start turns the run into a single flush.
        stop_pending_q <= ctrl_stop;
      end else if (state_q != ST_IDLE && ctrl_stop) begin
        stop_pending_q <= 1'b1;
      end

      if (state_q == ST_ARM && (arm_full || arm_part)) begin
        addr_q <= base_q + wptr_q;
        bc_q   <= arm_bc;
        beat_q <= '0;
      end else if (beat_acc) begin
        beat_q <= beat_q + 1'b1;
      end

      if (last_beat) begin
        if (ring_end) begin
`ifdef CAPTURE_DMA_WRAP_EN
          wptr_q    <= '0;
          wrapped_q <= 1'b1;
`else
          wptr_q    <= wptr_next;
          full_q    <= 1'b1;
`endif
        end else begin
          wptr_q <= wptr_next;
        end
      end
    end
  end

  assign avm_address    = addr_q;
  assign avm_burstcount = bc_q;
  assign avm_writedata  = in_data;
  assign avm_byteenable = '1;
  assign avm_read       = 1'b0;
  assign status_wptr    = wptr_q;
  assign status_wrapped = wrapped_q;
  assign status_full    = full_q;

endmodule

// File: tb/tb_capture_dma_writer.sv
// Bench for capture_dma_writer: a FIFO model feeds words, a scoreboard holds the
// expected {address, burstcount, data} of every beat and a monitor checks them.
module tb_capture_dma_writer;
  import la_pkg::*;

  localparam int LW = 16;
  localparam int EW = LA_SDRAM_ADDR_W + LA_BURSTCOUNT_W + LA_SDRAM_DATA_W;

  logic         clk = 1'b0;
  logic         reset;
  logic         ctrl_start, ctrl_stop;
  logic [26:0]  ctrl_base, ctrl_len;
  logic [255:0] in_data;
  logic         in_valid, in_ready;
  logic [LW-1:0] in_level;
  logic [26:0]  avm_address;
  logic [7:0]   avm_burstcount;
  logic         avm_write;
  logic [255:0] avm_writedata;
  logic [31:0]  avm_byteenable;
  logic         avm_read;
  logic         avm_waitrequest;
  logic         status_busy;
  logic [26:0]  status_wptr;
  logic         status_wrapped, status_full;

  capture_dma_writer #(.BURST_LEN(16), .LEVEL_W(LW)) dut (
    .clk(clk), .reset(reset),
    .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
    .ctrl_base(ctrl_base), .ctrl_len(ctrl_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_level(in_level),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .status_busy(status_busy), .status_wptr(status_wptr),
    .status_wrapped(status_wrapped), .status_full(status_full)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [255:0]  src_q[$];
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int wcnt     = 0;
  int popped   = 0;
  int wr_at    = -1;
  int wr_len   = 0;
  int gap_at   = -1;
  int gap_len  = 0;
  logic gate   = 1'b1;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic update_inputs();
    in_valid = gate && (src_q.size() > 0);
    in_data  = (src_q.size() > 0) ? src_q[0] : '0;
    in_level = LW'(src_q.size());
  endtask

  // One cycle of the upstream FIFO / slave model; returns at posedge + 1.
  task automatic tick();
    logic acc;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    #1;
    if (acc && src_q.size() > 0) begin
      void'(src_q.pop_front());
      popped++;
    end
    avm_waitrequest = 1'b0;
    gate = 1'b1;
    if (wr_len > 0 && popped == wr_at) begin
      avm_waitrequest = 1'b1;
      wr_len--;
    end
    if (gap_len > 0 && popped == gap_at) begin
      gate = 1'b0;
      gap_len--;
    end
    update_inputs();
  endtask

  task automatic load(input int n, input logic [7:0] tag, input logic [26:0] addr,
                      input logic [7:0] bc, input bit expect_it);
    logic [31:0]  w32;
    logic [255:0] w;
    for (int i = 0; i < n; i++) begin
      w32 = {tag, 8'hA5, 16'(wcnt)};
      w   = {8{w32}};
      wcnt++;
      src_q.push_back(w);
      if (expect_it) exp_q.push_back({addr, bc, w});
    end
    update_inputs();
  endtask

  task automatic start(input logic [26:0] base, input logic [26:0] len, input logic stop);
    ctrl_base  = base;
    ctrl_len   = len;
    ctrl_start = 1'b1;
    ctrl_stop  = stop;
    tick();
    ctrl_start = 1'b0;
    ctrl_stop  = 1'b0;
  endtask

  task automatic stop_pulse();
    ctrl_stop = 1'b1;
    tick();
    ctrl_stop = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain_timeout", EW'(exp_q.size() == 0), EW'(1));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (status_busy && k < budget) begin
      tick();
      k++;
    end
    chk("idle_timeout", EW'(status_busy), EW'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_avm_write"}, EW'(avm_write), EW'(0));
    chk({tag, "_avm_address"}, EW'(avm_address), EW'(0));
    chk({tag, "_avm_burstcount"}, EW'(avm_burstcount), EW'(0));
    chk({tag, "_in_ready"}, EW'(in_ready), EW'(0));
    chk({tag, "_busy"}, EW'(status_busy), EW'(0));
    chk({tag, "_wptr"}, EW'(status_wptr), EW'(0));
    chk({tag, "_wrapped"}, EW'(status_wrapped), EW'(0));
    chk({tag, "_full"}, EW'(status_full), EW'(0));
  endtask

  // scoreboard monitor: address/burstcount checked on every presented beat,
  // data checked and entry retired on every accepted beat
  always @(negedge clk) begin
    if (avm_write) begin
      if (exp_q.size() == 0) begin
        if (!avm_waitrequest) begin
          n_checks++;
          $display("FAIL unexpected_beat: got addr %h data %h expected no beat", avm_address, avm_writedata);
        end
      end else begin
        chk("burst_addr", EW'(avm_address), EW'(exp_q[0][EW-1 -: 27]));
        chk("burst_count", EW'(avm_burstcount), EW'(exp_q[0][263:256]));
        chk("byteenable", EW'(avm_byteenable), EW'(32'hFFFF_FFFF));
        if (!avm_waitrequest) begin
          chk("beat_data", EW'(avm_writedata), EW'(exp_q[0][255:0]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ctrl_start = 1'b0; ctrl_stop = 1'b0;
    ctrl_base = '0; ctrl_len = '0; avm_waitrequest = 1'b0;
    update_inputs();
    repeat (3) tick();
    chk_reset_outputs("reset");
    chk("avm_read", EW'(avm_read), EW'(0));
    reset = 1'b0;
    tick();

    // single full burst
    load(16, 8'h01, 27'h100, 8'd16, 1'b1);
    start(27'h100, 27'd32, 1'b0);
    wait_drain(100);
    repeat (3) tick();
    chk("t1_wptr", EW'(status_wptr), EW'(16));
    chk("t1_busy", EW'(status_busy), EW'(1));
    chk("t1_wrapped", EW'(status_wrapped), EW'(0));
    stop_pulse();
    wait_idle(20);

    // 48 words into a 32-word ring
    load(16, 8'h02, 27'h100, 8'd16, 1'b1);
    load(16, 8'h02, 27'h110, 8'd16, 1'b1);
`ifdef CAPTURE_DMA_WRAP_EN
    load(16, 8'h02, 27'h100, 8'd16, 1'b1);
    start(27'h100, 27'd32, 1'b0);
    wait_drain(200);
    repeat (3) tick();
    chk("t2_wrapped", EW'(status_wrapped), EW'(1));
    chk("t2_wptr", EW'(status_wptr), EW'(16));
    chk("t2_full", EW'(status_full), EW'(0));
    chk("t2_busy", EW'(status_busy), EW'(1));
    stop_pulse();
    wait_idle(20);
`else
    load(16, 8'h02, 27'h000, 8'd0, 1'b0);
    start(27'h100, 27'd32, 1'b0);
    wait_drain(200);
    repeat (3) tick();
    chk("t2_full", EW'(status_full), EW'(1));
    chk("t2_busy", EW'(status_busy), EW'(0));
    chk("t2_wptr", EW'(status_wptr), EW'(32));
    chk("t2_wrapped", EW'(status_wrapped), EW'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_in_ready_held", EW'(in_ready), EW'(0));
    end
    chk("t2_words_left", EW'(src_q.size()), EW'(16));
    src_q.delete();
    update_inputs();
`endif

    // stop flush with 5 words left after a full burst
    load(16, 8'h03, 27'h200, 8'd16, 1'b1);
    load(5, 8'h03, 27'h210, 8'd5, 1'b1);
    start(27'h200, 27'd64, 1'b0);
    for (int k = 0; k < 100 && exp_q.size() > 5; k++) tick();
    repeat (5) tick();
    chk("t3_busy_armed", EW'(status_busy), EW'(1));
    chk("t3_words_held", EW'(src_q.size()), EW'(5));
    chk("t3_wptr_mid", EW'(status_wptr), EW'(16));
    stop_pulse();
    wait_drain(50);
    wait_idle(20);
    chk("t3_wptr", EW'(status_wptr), EW'(21));
    chk("t3_busy", EW'(status_busy), EW'(0));

    // waitrequest stall on beat 4 and a valid gap after beat 9
    load(16, 8'h04, 27'h300, 8'd16, 1'b1);
    popped = 0; wr_at = 4; wr_len = 3; gap_at = 9; gap_len = 2;
    start(27'h300, 27'd32, 1'b0);
    wait_drain(100);
    repeat (3) tick();
    chk("t4_wptr", EW'(status_wptr), EW'(16));
    chk("t4_words_left", EW'(src_q.size()), EW'(0));
    chk("t4_popped", EW'(popped), EW'(16));
    stop_pulse();
    wait_idle(20);

    // reset during beat 7, then restart from base
    load(16, 8'h05, 27'h400, 8'd16, 1'b1);
    popped = 0;
    start(27'h400, 27'd32, 1'b0);
    for (int k = 0; k < 100 && popped < 7; k++) tick();
    chk("t5_reached_beat7", EW'(popped), EW'(7));
    reset = 1'b1;
    tick();
    chk_reset_outputs("t5_midreset");
    reset = 1'b0;
    exp_q.delete();
    src_q.delete();
    update_inputs();
    tick();
    load(16, 8'h06, 27'h400, 8'd16, 1'b1);
    start(27'h400, 27'd32, 1'b0);
    wait_drain(100);
    repeat (3) tick();
    chk("t5_wptr", EW'(status_wptr), EW'(16));
    stop_pulse();
    wait_idle(20);

    // start and stop together: one-shot flush of 3 words
    load(3, 8'h07, 27'h500, 8'd3, 1'b1);
    start(27'h500, 27'd16, 1'b1);
    wait_drain(50);
    wait_idle(20);
    chk("t6_wptr", EW'(status_wptr), EW'(3));
    chk("t6_wrapped", EW'(status_wrapped), EW'(0));
    chk("t6_full", EW'(status_full), EW'(0));

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
